// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl
// Frame-level sequencer for the Viterbi transmit/receive test path.
//
// What it does:
//   - Accepts FRAME_LEN payload bits from the source (valid/ready) and
//     drives the encoder enable/data lines.
//   - Appends TAIL_LEN zero bits to flush the trellis.
//   - Compares decoder output against a stored copy of the payload and
//     counts bit errors (saturating).
//   - Optionally generates an LFSR-based channel error mask and counts
//     the injected errors (saturating).
//
// Optional feature: define VITERBI_ERR_INJ_EN to build the error LFSR,
// chan_flip_o and inj_ct_o. When it is undefined, chan_flip_o and inj_ct_o
// are tied to zero, and the ERR_BITS parameter does not exist.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   start_i             begin a frame (honoured only in IDLE)
//   src_valid_i/src_bit_i/src_ready_o   payload source handshake
//   enc_en_o/enc_bit_o  encoder enable/data (combinational)
//   chan_flip_o         registered XOR mask for the encoder output symbol
//   dec_valid_i/dec_bit_i  decoder output bit stream
//   busy_o, done_o      FSM not idle; one-cycle completion pulse
//   bit_err_ct_o        decoded bit mismatches in current/last frame
//   inj_ct_o            flipped channel symbols in current/last frame
//
// state   | meaning
// IDLE    | waiting for start_i; counters hold the last frame's results
// PAYLOAD | accepting FRAME_LEN source bits into the encoder and ref FIFO
// TAIL    | driving TAIL_LEN zero flush bits into the encoder
// DRAIN   | waiting for remaining decoder compares, bounded by DRAIN_MAX
// DONE    | one-cycle completion pulse
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN  = 2,
`ifdef VITERBI_ERR_INJ_EN
  parameter int ERR_BITS  = 5,
`endif
  parameter int DRAIN_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        src_valid_i,
  input  logic        src_bit_i,
  output logic        src_ready_o,
  output logic        enc_en_o,
  output logic        enc_bit_o,
  output logic [1:0]  chan_flip_o,
  input  logic        dec_valid_i,
  input  logic        dec_bit_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bit_err_ct_o,
  output logic [15:0] inj_ct_o
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_C      = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TAIL_LOAD   = TW'(TAIL_LEN - 1);
  localparam logic [DW-1:0] DRAIN_LOAD  = DW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_TAIL    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   pay_q, pay_d;
  logic [CW-1:0]   cmp_q, cmp_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [TW-1:0]   tail_q, tail_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [15:0]     err_q, err_d;
  logic            fifo_mem [FRAME_LEN];

  logic            start_frame;
  logic            push;
  logic            pop;
  logic            chk_act;
  logic            head;

  // FSM next state and combinational encoder/source outputs
  always_comb begin
    state_d     = state_q;
    tail_d      = tail_q;
    drain_d     = drain_q;
    src_ready_o = 1'b0;
    enc_en_o    = 1'b0;
    enc_bit_o   = 1'b0;
    start_frame = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_PAYLOAD;
          start_frame = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        src_ready_o = 1'b1;
        if (src_valid_i) begin
          enc_en_o  = 1'b1;
          enc_bit_o = src_bit_i;
          push      = 1'b1;
          if (pay_q == LAST_C) begin
            state_d = ST_TAIL;
            tail_d  = TAIL_LOAD;
          end
        end
      end
      ST_TAIL: begin
        enc_en_o = 1'b1;
        if (tail_q == '0) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          tail_d = tail_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cmp_q == FRAME_LEN_C || drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reference FIFO and decoder compare datapath
  assign chk_act = (state_q == ST_PAYLOAD) || (state_q == ST_TAIL) ||
                   (state_q == ST_DRAIN);
  assign head    = fifo_mem[rd_q];
  assign pop     = chk_act && dec_valid_i && (occ_q != '0) && (cmp_q < FRAME_LEN_C);

  always_comb begin
    pay_d = pay_q;
    cmp_d = cmp_q;
    occ_d = occ_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    err_d = err_q;
    if (start_frame) begin
      pay_d = '0;
      cmp_d = '0;
      occ_d = '0;
      wr_d  = '0;
      rd_d  = '0;
      err_d = '0;
    end else begin
      if (push) begin
        pay_d = pay_q + 1'b1;
        wr_d  = wr_q + 1'b1;
      end
      if (pop) begin
        cmp_d = cmp_q + 1'b1;
        rd_d  = rd_q + 1'b1;
        if ((head ^ dec_bit_i) && (err_q != 16'hFFFF)) begin
          err_d = err_q + 16'd1;
        end
      end
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pay_q   <= '0;
      cmp_q   <= '0;
      occ_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      tail_q  <= '0;
      drain_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
      cmp_q   <= cmp_d;
      occ_q   <= occ_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      tail_q  <= tail_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

  // Payload storage needs no reset: occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_q] <= src_bit_i;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign bit_err_ct_o = err_q;

`ifdef VITERBI_ERR_INJ_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  flip_q, flip_d;
  logic [15:0] inj_q, inj_d;
  logic        hit;

  // The hit uses the pre-advance LFSR value so the registered mask lines up
  // with the encoder symbol produced from this cycle's enable.
  assign hit = enc_en_o && (&lfsr_q[ERR_BITS-1:0]);

  always_comb begin
    lfsr_d = lfsr_q;
    inj_d  = inj_q;
    flip_d = hit ? 2'b11 : 2'b00;
    if (start_frame) begin
      lfsr_d = 16'hACE1;
      inj_d  = '0;
    end else begin
      if (enc_en_o) begin
        // Fibonacci taps x^16 + x^14 + x^13 + x^11 + 1
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
      if (hit && (inj_q != 16'hFFFF)) begin
        inj_d = inj_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 16'hACE1;
      flip_q <= 2'b00;
      inj_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      flip_q <= flip_d;
      inj_q  <= inj_d;
    end
  end

  assign chan_flip_o = flip_q;
  assign inj_ct_o    = inj_q;
`else
  assign chan_flip_o = 2'b00;
  assign inj_ct_o    = 16'h0000;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
module tb_viterbi_frame_ctrl;

  localparam int FL = 64;
`ifdef VITERBI_ERR_INJ_EN
  localparam int EB  = 1;
  localparam bit INJ = 1'b1;
`else
  localparam int EB  = 5;
  localparam bit INJ = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        src_valid_i;
  logic        src_bit_i;
  logic        src_ready_o;
  logic        enc_en_o;
  logic        enc_bit_o;
  logic [1:0]  chan_flip_o;
  logic        dec_valid_i;
  logic        dec_bit_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] bit_err_ct_o;
  logic [15:0] inj_ct_o;

  viterbi_frame_ctrl #(
    .FRAME_LEN (FL),
    .TAIL_LEN  (2),
`ifdef VITERBI_ERR_INJ_EN
    .ERR_BITS  (EB),
`endif
    .DRAIN_MAX (255)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .src_valid_i  (src_valid_i),
    .src_bit_i    (src_bit_i),
    .src_ready_o  (src_ready_o),
    .enc_en_o     (enc_en_o),
    .enc_bit_o    (enc_bit_o),
    .chan_flip_o  (chan_flip_o),
    .dec_valid_i  (dec_valid_i),
    .dec_bit_i    (dec_bit_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .bit_err_ct_o (bit_err_ct_o),
    .inj_ct_o     (inj_ct_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  task automatic check(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic bit lfsr_hit(input logic [15:0] l);
    int mask;
    mask = (1 << EB) - 1;
    return ((int'(l) & mask) == mask);
  endfunction

  // Flips expected over n encoder-enable cycles starting from the seed.
  function automatic int inj_model(input int n);
    logic [15:0] l;
    int cnt;
    l = 16'hACE1;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (lfsr_hit(l)) cnt++;
      l = lfsr_adv(l);
    end
    return INJ ? cnt : 0;
  endfunction

  typedef struct {
    int err;
    int inj;
    int en;
    int acc;
    int tail;
    int gap;
  } exp_t;

  exp_t sb[$];

  // Decoder stub: echoes the encoder input stream 3 cycles later, with
  // selected echo indices inverted and an optional cap on emitted bits.
  int   stub_limit   = 1000;
  int   stub_inv_a   = -1;
  int   stub_inv_b   = -1;
  int   stub_emitted = 0;

  initial begin : stub
    logic dly_v [3];
    logic dly_b [3];
    logic ov, ob;
    dec_valid_i = 1'b0;
    dec_bit_i   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dly_v[i] = 1'b0;
      dly_b[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      ov = dly_v[2];
      ob = dly_b[2];
      dly_v[2] = dly_v[1];
      dly_b[2] = dly_b[1];
      dly_v[1] = dly_v[0];
      dly_b[1] = dly_b[0];
      dly_v[0] = enc_en_o;
      dly_b[0] = enc_bit_o;
      if (ov && stub_emitted < stub_limit) begin
        dec_valid_i = 1'b1;
        dec_bit_i   = ob ^ ((stub_emitted == stub_inv_a) || (stub_emitted == stub_inv_b));
        stub_emitted++;
      end else begin
        dec_valid_i = 1'b0;
        dec_bit_i   = 1'b0;
      end
    end
  end

  // Monitor: tracks per-frame activity and checks it at every done_o.
  initial begin : monitor
    logic [15:0] lfsr_m;
    logic [1:0]  exp_flip;
    bit          done_prev;
    int cyc, last_en, en_ct, acc_ct, tail_ct, path_bad, flip_bad;
    exp_t e;
    lfsr_m = 16'hACE1;
    exp_flip = 2'b00;
    done_prev = 1'b0;
    cyc = 0; last_en = 0; en_ct = 0; acc_ct = 0; tail_ct = 0;
    path_bad = 0; flip_bad = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        lfsr_m    = 16'hACE1;
        exp_flip  = 2'b00;
        done_prev = 1'b0;
      end else begin
        if (chan_flip_o !== exp_flip) flip_bad++;
        exp_flip = (INJ && enc_en_o && lfsr_hit(lfsr_m)) ? 2'b11 : 2'b00;
        if (start_i && !busy_o) begin
          lfsr_m = 16'hACE1;
          en_ct = 0; acc_ct = 0; tail_ct = 0; path_bad = 0; flip_bad = 0;
        end else if (enc_en_o) begin
          lfsr_m = lfsr_adv(lfsr_m);
        end
        if (enc_en_o) begin
          en_ct++;
          last_en = cyc;
        end
        if (src_valid_i && src_ready_o) begin
          acc_ct++;
          if (!enc_en_o || enc_bit_o !== src_bit_i) path_bad++;
        end
        if (src_ready_o && !src_valid_i && enc_en_o) path_bad++;
        if (enc_en_o && !src_ready_o) begin
          tail_ct++;
          if (enc_bit_o) path_bad++;
        end
        if (done_o) begin
          done_seen++;
          check("done_single_pulse", int'(done_prev), 0);
          check("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("bit_err_ct", int'(bit_err_ct_o), e.err);
            check("inj_ct", int'(inj_ct_o), e.inj);
            check("enc_en_cycles", en_ct, e.en);
            check("accepts", acc_ct, e.acc);
            check("tail_cycles", tail_ct, e.tail);
            check("enc_path", path_bad, 0);
            check("chan_flip_lag", flip_bad, 0);
            if (e.gap >= 0) check("drain_to_done", cyc - last_en, e.gap);
          end
        end
        done_prev = done_o;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic run_frame(input logic [63:0] pl, input bit throttle,
                           input int inv_a, input int inv_b, input int limit,
                           input int start_at, input int exp_err, input int exp_gap);
    exp_t e;
    int   i, budget;
    bit   v, acc, seen;
    src_valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    stub_inv_a   = inv_a;
    stub_inv_b   = inv_b;
    stub_limit   = limit;
    stub_emitted = 0;
    e.err  = exp_err;
    e.inj  = inj_model(FL + 2);
    e.en   = FL + 2;
    e.acc  = FL;
    e.tail = 2;
    e.gap  = exp_gap;
    sb.push_back(e);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    i = 0;
    v = 1'b1;
    budget = 0;
    while (i < FL && budget < 1000) begin
      src_valid_i = v;
      src_bit_i   = pl[i];
      start_i     = (start_at >= 0 && i == start_at && v);
      acc         = src_valid_i && src_ready_o;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      if (acc) i++;
      if (throttle) v = !v;
      budget++;
    end
    src_valid_i = 1'b0;
    check("payload_accepted", i, FL);
    seen = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      seen = done_o;
    end
    check("done_reached", int'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_src_ready"}, int'(src_ready_o), 0);
    check({tag, "_enc_en"}, int'(enc_en_o), 0);
    check({tag, "_enc_bit"}, int'(enc_bit_o), 0);
    check({tag, "_chan_flip"}, int'(chan_flip_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_bit_err"}, int'(bit_err_ct_o), 0);
    check({tag, "_inj"}, int'(inj_ct_o), 0);
  endtask

  initial begin : stimulus
    rst         = 1'b0;
    start_i     = 1'b0;
    src_valid_i = 1'b1;
    src_bit_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    src_valid_i = 1'b0;
    src_bit_i   = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;

    // clean loopback, continuous source
    run_frame(64'hDEADBEEF0123ABCD, 1'b0, -1, -1, 1000, -1, 0, -1);
    // source valid on alternate cycles
    run_frame(64'h5A5AF00F3C3C9669, 1'b1, -1, -1, 1000, -1, 0, -1);
    // decoder echo with bits 3 and 40 inverted
    run_frame(64'hFFFF0000AAAA5555, 1'b0, 3, 40, 1000, -1, 2, -1);
    // only 10 decoder bits, bit 5 inverted: drain timeout
    run_frame(64'h13579BDF2468ACE0, 1'b0, 5, -1, 10, -1, 1, 256);

    // partial frame followed by asynchronous reset
    repeat (6) @(posedge clk);
    #1;
    stub_inv_a   = 3;
    stub_inv_b   = -1;
    stub_limit   = 1000;
    stub_emitted = 0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      src_valid_i = 1'b1;
      src_bit_i   = k[0] ^ k[2];
      @(posedge clk);
      #1;
    end
    src_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_bit_err", int'(bit_err_ct_o), 1);
    check("pre_reset_busy", int'(busy_o), 1);
    src_valid_i = 1'b1;
    src_bit_i   = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    src_valid_i = 1'b0;
    src_bit_i   = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;

    // clean frame after reset: any stale FIFO content would cause errors
    run_frame(64'hC3A50F1E7B2D9E48, 1'b0, -1, -1, 1000, -1, 0, -1);
    // start_i pulsed mid-payload must not restart or clear counters
    run_frame(64'h0123456789ABCDEF, 1'b0, 3, 40, 1000, 50, 2, -1);

    repeat (4) @(posedge clk);
    #1;
    check("done_pulse_count", done_seen, 6);
    check("sb_remaining", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame-level sequencer for the Viterbi transmit/receive test path. It takes payload bits from a source through a valid/ready handshake and drives the convolutional encoder's enable and data inputs. After each frame it appends zero tail bits to flush the trellis, and it generates a pseudo-random channel error mask for the encoder's 2-bit output. It also checks decoder output against a stored copy of the payload, and reports bit errors and injected-error counts per frame.

## Interface
- FRAME_LEN, 64: payload bits per frame (power of 2, 8..256)
- TAIL_LEN, 2: zero flush bits appended after payload (constraint length K-1)
- ERR_BITS, 5: channel symbol is flipped when LFSR[ERR_BITS-1:0] is all ones (rate 2^-ERR_BITS)
- DRAIN_MAX, 255: cycles allowed in DRAIN before forced completion
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a frame; honoured only in IDLE
- src_valid_i  in  1  source payload bit valid
- src_bit_i  in  1  source payload bit
- src_ready_o  out  1  controller accepts a payload bit
- enc_en_o  out  1  encoder enable
- enc_bit_o  out  1  encoder data input
- chan_flip_o  out  2  XOR mask for the encoder output symbol
- dec_valid_i  in  1  decoder output bit valid
- dec_bit_i  in  1  decoder output bit
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  one-cycle pulse at frame completion
- bit_err_ct_o  out  16  decoded bit mismatches in current/last frame, saturating
- inj_ct_o  out  16  flipped channel symbols in current/last frame, saturating

## Operation
- FSM states: IDLE, PAYLOAD, TAIL, DRAIN, DONE.
- IDLE → PAYLOAD on start_i. Entry clears both counters, the payload count, the compare count and the reference FIFO, and reseeds the LFSR to 16'hACE1.
- PAYLOAD:
  - src_ready_o=1.
  - On src_valid_i&&src_ready_o: enc_en_o=1, enc_bit_o=src_bit_i, the bit is pushed into the reference FIFO (depth FRAME_LEN), and the payload count increments.
  - No valid bit: enc_en_o=0.
  - After the FRAME_LEN-th accept → TAIL.
- TAIL: src_ready_o=0, enc_en_o=1, enc_bit_o=0 for exactly TAIL_LEN cycles → DRAIN.
- DRAIN: enc_en_o=0. Go to DONE when compare count == FRAME_LEN, or after DRAIN_MAX cycles in DRAIN.
- DONE: done_o=1 for one cycle → IDLE. Counters hold their values until the next start_i.
- Decoder check:
  - When dec_valid_i is high, the FIFO is non-empty, and compare count < FRAME_LEN: pop the FIFO head, bit_err_ct_o += (head ^ dec_bit_i), and increment the compare count.
  - Otherwise dec_valid_i is ignored (covers tail-bit outputs and stale outputs).
  - The check is active in PAYLOAD, TAIL and DRAIN; dec_valid_i is ignored in IDLE and DONE.
- Error LFSR:
  - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
  - Advances once per cycle with enc_en_o=1.
- Counter arithmetic: 16-bit; saturate at 16'hFFFF, never wrap.
- start_i outside IDLE is ignored.
- src_valid_i outside PAYLOAD is not accepted; the source holds its bit.

## Timing
- Reset values:
  - state IDLE, LFSR 16'hACE1, FIFO empty, all internal counts 0.
  - Outputs src_ready_o=0, enc_en_o=0, enc_bit_o=0, chan_flip_o=2'b00, busy_o=0, done_o=0, bit_err_ct_o=0, inj_ct_o=0.
- enc_en_o, enc_bit_o and src_ready_o are combinational from state and src_valid_i. The encoder registers them, so its output symbol appears one cycle after enc_en_o.
- chan_flip_o is registered:
  - In cycle t+1 it equals 2'b11 if enc_en_o was 1 in cycle t and LFSR[ERR_BITS-1:0] was all ones in cycle t (pre-advance value); otherwise 2'b00.
  - This aligns the mask with the encoder output of cycle t.
  - inj_ct_o increments in the same cycle chan_flip_o goes to 2'b11.
- busy_o goes high the cycle after start_i is sampled and is low again the cycle after done_o.
- Minimum frame length in cycles: 1 (IDLE→PAYLOAD) + FRAME_LEN + TAIL_LEN + 1 (DRAIN) + 1 (DONE), assuming continuous src_valid_i and compares complete in time.
- FIFO push and pop in the same cycle are both honoured, and FIFO occupancy is unchanged.
- Reset asserted mid-frame returns to the reset values immediately (asynchronously); the partial frame is discarded.

## Configuration
- VITERBI_ERR_INJ_EN defined: LFSR, chan_flip_o and inj_ct_o operate as above.
- VITERBI_ERR_INJ_EN undefined: LFSR not built, chan_flip_o tied to 2'b00, inj_ct_o tied to 0. All other behaviour is unchanged.

## Test plan
- Clean loopback, VITERBI_ERR_INJ_EN undefined, FRAME_LEN=64, continuous src_valid_i, decoder in the loop → done_o after all 64 compares, bit_err_ct_o=0, inj_ct_o=0, enc_en_o high for exactly 66 cycles.
- Source throttling: src_valid_i high on alternate cycles → exactly 64 accepts; enc_en_o low on the idle cycles; TAIL drives enc_bit_o=0 for 2 cycles.
- Injection, VITERBI_ERR_INJ_EN defined, ERR_BITS=1 (rate 1/2) → inj_ct_o equals the count of flips predicted by a bench LFSR model seeded 16'hACE1; chan_flip_o lags enc_en_o by one cycle.
- Forced mismatch: bench decoder stub echoes the payload with bits 3 and 40 inverted → bit_err_ct_o=2 at done_o.
- Drain timeout: decoder stub emits only 10 valid bits → DONE entered exactly 255 cycles after entering DRAIN, bit_err_ct_o reflects 10 compares, done_o pulses once.
- Reset and ignore: assert rst after 20 payload bits → all outputs at reset values, FIFO empty; start_i pulsed while busy_o=1 → no effect on state or counters.
